// File: rtl/data_ram_responder_pkg.sv
// data_ram_responder_pkg: constants shared by the memory controller and the data RAM responder
package data_ram_responder_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ = 1'b0;
  typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/data_ram_responder_ram_array_1rw.sv
// ram_array_1rw: single-port synchronous RAM with registered, clearable read data
module ram_array_1rw
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_o <= '0;
    else if (rclr_i) rdata_o <= '0;
    else if (re_i) rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: word-addressed data RAM answering the memory controller after fixed wait states
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = WAIT_STATES > 1 ? $clog2(WAIT_STATES) : 1;
  state_e            state_q;
  logic [AW-1:0]     ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
  logic              cap;
  logic              clr;
  logic              go_resp;
  logic              in_range;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_rw;
  logic [DATA_W-1:0] acc_wdata;
  logic              ram_we;
  logic              ram_re;
  logic              ram_rclr;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  // With no wait states the access happens at the capture edge, so it must use the live inputs.
  always_comb begin
    cap = state_q == IDLE;
    clr = state_q == INIT;
    acc_addr = cap ? addr : addr_q;
    acc_rw = cap ? rw : rw_q;
    acc_wdata = cap ? wdata : wdata_q;
    in_range = 32'(acc_addr) < DEPTH;
    go_resp = (cap && req && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == CW'(WAIT_STATES - 1));
    ram_we = clr || (go_resp && in_range && acc_rw == RW_WRITE);
    ram_re = go_resp && in_range && acc_rw == RW_READ;
    ram_rclr = go_resp && !in_range;
    ram_addr = clr ? ptr_q : acc_addr[AW-1:0];
    ram_wdata = clr ? '0 : acc_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      rw_q <= RW_READ;
      wdata_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_q <= IDLE;
            busy_q <= 1'b0;
          end
        end
        IDLE: if (req) begin
          addr_q <= addr;
          rw_q <= rw;
          wdata_q <= wdata;
          cnt_q <= '0;
          busy_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: cnt_q <= cnt_q + CW'(1);
        RESP: begin
          state_q <= IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
      if (go_resp) begin
        state_q <= RESP;
        ack_q <= 1'b1;
        err_q <= !in_range;
      end
    end
  end
  ram_array_1rw #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .rst(rst),
    .we_i(ram_we),
    .re_i(ram_re),
    .rclr_i(ram_rclr),
    .addr_i(ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(rdata)
  );
  assign ack = ack_q;
  assign err = err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: vector table, corner sequences and random traffic against a word-array model
module tb_data_ram_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req [2];
  logic rw [2];
  logic [15:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic ack [2];
  logic err [2];
  logic busy [2];
  logic [31:0] mm [2][256];
  logic [31:0] mr [2];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  data_ram_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req(req[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );
  data_ram_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_ws0 (
    .clk(clk), .rst(rst), .req(req[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      mr[u] = '0;
      for (int i = 0; i < 256; i++) mm[u][i] = '0;
    end
  endtask

  // Expects rst already high; holds it two cycles, releases, and times the clear.
  task automatic release_and_clear();
    int cyc = 0;
    int bad = 0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy[0] & busy[1]), 32'd1);
    chk("reset_outputs", rdata[0] | rdata[1] | 32'({ack[0] | ack[1], err[0] | err[1]}), 32'd0);
    rst = 1'b0;
    while (busy[0] && cyc < 300) begin
      cyc++;
      if (ack[0] || ack[1] || rdata[0] != 0 || rdata[1] != 0 || busy[1] != busy[0]) bad++;
      @(negedge clk);
    end
    chk("clear_cycles", cyc, 32'd256);
    chk("clear_quiet", bad, 32'd0);
    chk("idle_busy_ws0", 32'(busy[1]), 32'd0);
  endtask

  task automatic do_access(input int u, input logic w, input logic [15:0] a, input logic [31:0] d,
                           input bit glitch, output logic [31:0] got_r, output logic got_e);
    int k = 1;
    int n = 0;
    int ws = (u == 1) ? 0 : 2;
    logic exp_e;
    while (busy[u] && n < 400) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("u%0d_idle_before_req", u), 32'(busy[u]), 32'd0);
    req[u] = 1'b1;
    rw[u] = w;
    addr[u] = a;
    wdata[u] = d;
    @(negedge clk);
    req[u] = 1'b0;
    if (glitch) begin
      addr[u] = 16'h0005;
      wdata[u] = 32'h0000FFFF;
      rw[u] = ~w;
    end
    while (ack[u] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    exp_e = a >= 16'd256;
    if (exp_e) mr[u] = '0;
    else if (w) mm[u][a[7:0]] = d;
    else mr[u] = mm[u][a[7:0]];
    got_r = rdata[u];
    got_e = err[u];
    chk($sformatf("u%0d_latency a=%h", u, a), k, ws + 1);
    chk($sformatf("u%0d_rdata a=%h", u, a), rdata[u], mr[u]);
    chk($sformatf("u%0d_err a=%h", u, a), 32'(err[u]), 32'(exp_e));
    if (glitch) req[u] = 1'b1;
    @(negedge clk);
    req[u] = 1'b0;
    chk($sformatf("u%0d_ack_one_cycle", u), 32'({ack[u], err[u]}), 32'd0);
    if (glitch) begin
      n = 0;
      repeat (ws + 3) begin
        @(negedge clk);
        if (ack[u]) n++;
      end
      chk("no_queued_ack", n, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic e;
    logic [15:0] a;
    int n;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0;
      rw[u] = 1'b0;
      addr[u] = '0;
      wdata[u] = '0;
    end
    tbl[0]  = '{1'b1, 16'h0021, 32'h00000003, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b0, 16'h0021, 32'h00000000, 32'h00000003, 1'b0};
    tbl[2]  = '{1'b0, 16'h0011, 32'h00000000, 32'h00000000, 1'b0};
    tbl[3]  = '{1'b1, 16'h0100, 32'hDEADBEEF, 32'h00000000, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[5]  = '{1'b1, 16'h00FF, 32'h12345678, 32'h00000000, 1'b0};
    tbl[6]  = '{1'b0, 16'h00FF, 32'h00000000, 32'h12345678, 1'b0};
    tbl[7]  = '{1'b0, 16'h0021, 32'h00000000, 32'h00000003, 1'b0};
    tbl[8]  = '{1'b1, 16'h0021, 32'hAAAA5555, 32'h00000003, 1'b0};
    tbl[9]  = '{1'b1, 16'hFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    tbl[10] = '{1'b0, 16'h0021, 32'h00000000, 32'hAAAA5555, 1'b0};
    #1 rst = 1'b1;
    release_and_clear();
    for (int i = 0; i < 11; i++) begin
      do_access(0, tbl[i].rw, tbl[i].addr, tbl[i].wdata, 1'b0, r, e);
      chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
    end
    do_access(0, 1'b1, 16'h0009, 32'h00000006, 1'b1, r, e);
    do_access(0, 1'b0, 16'h0009, 32'h0, 1'b0, r, e);
    chk("hold_addr9", r, 32'h00000006);
    do_access(0, 1'b0, 16'h0005, 32'h0, 1'b0, r, e);
    chk("hold_addr5", r, 32'h00000000);
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 40; i++) begin
        n = $urandom_range(0, 9);
        a = (n == 0) ? 16'($urandom_range(256, 65535)) : (n == 1) ? 16'h00FF : 16'($urandom_range(0, 31));
        do_access(u, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, r, e);
      end
    end
    do_access(0, 1'b1, 16'h0030, 32'hA5A50001, 1'b0, r, e);
    do_access(0, 1'b0, 16'h0030, 32'h0, 1'b0, r, e);
    n = 0;
    while (busy[0] && n < 400) begin
      n++;
      @(negedge clk);
    end
    req[0] = 1'b1;
    rw[0] = 1'b1;
    addr[0] = 16'h0003;
    wdata[0] = 32'h0000000C;
    @(negedge clk);
    req[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'({busy[0], busy[1]}), 32'd3);
    chk("async_rdata", rdata[0], 32'd0);
    chk("async_ack", 32'({ack[0], ack[1]}), 32'd0);
    release_and_clear();
    do_access(0, 1'b0, 16'h0003, 32'h0, 1'b0, r, e);
    chk("abandoned_write", r, 32'h00000000);
    do_access(1, 1'b1, 16'h0003, 32'h0000000C, 1'b0, r, e);
    do_access(1, 1'b0, 16'h0003, 32'h0, 1'b0, r, e);
    chk("ws0_readback", r, 32'h0000000C);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
